// File: rtl/e_mdu.sv
// e_mdu -- E-stage multiply/divide unit holding the architectural HI/LO pair.
//
// Accepts mult/multu/div/divu (and madd/maddu/msub/msubu when the MDU_MADD_EN
// macro is defined) on a one-cycle start pulse. Every operation has a fixed
// latency. The 64-bit result is computed at acceptance, parked in pending
// registers, and committed to HI/LO when the busy counter runs out.
// mthi/mtlo write HI/LO directly while idle. mfhi/mflo read them through C.
//
// Parameters:
//   MULT_CYCLES  busy cycles for the multiply family (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        E-stage instruction is a multiply/divide (one-cycle pulse)
//   op[3:0]      operation select (1 mult .. 12 msubu, 5/6 mfhi/mflo, 7/8 mthi/mtlo)
//   A, B         forwarded rs / rt operands
//   busy         operation in progress
//   HI, LO       visible HI/LO registers
//   C            HI for mfhi, LO for mflo, else 0 (combinational)
// Build option:
//   MDU_MADD_EN  when defined, ops 9..12 accumulate into {HI,LO};
//                otherwise they behave as "none".
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] C
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // 32x32 -> 64 product; sgn selects two's-complement operands.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] as;
    logic signed [63:0] bs;
    as = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bs = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return as * bs;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // quotient truncates toward zero and the remainder follows the dividend.
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ua = neg_a ? (32'd0 - a) : a;
    ub = neg_b ? (32'd0 - b) : b;
    q = (ub == 32'd0) ? 32'd0 : (ua / ub);
    r = (ub == 32'd0) ? 32'd0 : (ua % ub);
    if (neg_a ^ neg_b) q = 32'd0 - q;
    if (neg_a) r = 32'd0 - r;
    return {r, q};
  endfunction

  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi_p1;
  logic [31:0]      pend_lo_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [63:0]      prod;
  logic [63:0]      res;
  logic             res_ok;
  logic             legal;
  logic [CNT_W-1:0] cyc_ld;
  logic             accept;

  always_comb begin
    res    = 64'd0;
    res_ok = 1'b1;
    legal  = 1'b0;
    cyc_ld = CNT_W'(MULT_CYCLES);
    prod   = mul64(A, B, (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB));
    case (op)
      OP_MULT, OP_MULTU: begin
        legal = 1'b1;
        res   = prod;
      end
      OP_DIV, OP_DIVU: begin
        legal  = 1'b1;
        cyc_ld = CNT_W'(DIV_CYCLES);
        res    = div64(A, B, op == OP_DIV);
        res_ok = (B != 32'd0);
      end
      OP_MADD, OP_MADDU: begin
        legal = MADD_EN;
        res   = {hi_q, lo_q} + prod;
      end
      OP_MSUB, OP_MSUBU: begin
        legal = MADD_EN;
        res   = {hi_q, lo_q} - prod;
      end
      default: ;
    endcase
  end

  assign busy   = (cnt_p1 != '0);
  assign accept = start & ~busy & legal;

  // Stage p1: pending result and countdown; commit into HI/LO on 1 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1     <= '0;
      vld_p1     <= 1'b0;
      pend_hi_p1 <= 32'd0;
      pend_lo_p1 <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else if (accept) begin
      cnt_p1     <= cyc_ld;
      vld_p1     <= res_ok;
      pend_hi_p1 <= res[63:32];
      pend_lo_p1 <= res[31:0];
    end else if (busy) begin
      cnt_p1 <= cnt_p1 - 1'b1;
      if ((cnt_p1 == CNT_W'(1)) && vld_p1) begin
        hi_q <= pend_hi_p1;
        lo_q <= pend_lo_p1;
      end
    end else begin
      if (op == OP_MTHI) hi_q <= A;
      if (op == OP_MTLO) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;
  assign C  = (op == OP_MFHI) ? hi_q :
              (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed scenarios followed by randomized traffic,
// checked every cycle against a timing-window reference model that computes
// results with plain integer arithmetic.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] C;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .C(C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural HI/LO plus the window of cycles in which
  // the unit is busy, and the result that lands at the end of the window.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pok, m_active, m_known;
  int          cyc, m_start, m_end;

  function automatic bit m_legal(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD && o >= 4'd9 && o <= 4'd12);
  endfunction

  function automatic logic [63:0] m_result(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q, r;
    logic [63:0]     acc;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = longint'({32'd0, a}) * longint'({32'd0, b});
    acc = {hi, lo};
    case (o)
      4'd1: return 64'(sp);
      4'd2: return 64'(up);
      4'd3: begin
        sa = $signed(a); sb = $signed(b);
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb; r = sa % sb;
        return {32'(r), 32'(q)};
      end
      4'd4: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      4'd9:  return acc + 64'(sp);
      4'd10: return acc + 64'(up);
      4'd11: return acc - 64'(sp);
      4'd12: return acc - 64'(up);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit m_busy();
    return m_active && (cyc > m_start) && (cyc <= m_end);
  endfunction

  task automatic check_model();
    logic [31:0] ec;
    ec = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("C", C, ec);
  endtask

  task automatic model_edge();
    logic [63:0] r;
    bit          bz;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_active = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      bz = m_busy();
      if (m_active && cyc == m_end) begin
        if (m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        m_active = 1'b0;
      end
      if (!bz) begin
        if (start && m_legal(op)) begin
          r = m_result(op, A, B, m_hi, m_lo);
          m_phi = r[63:32]; m_plo = r[31:0];
          m_pok = !((op == 4'd3 || op == 4'd4) && B == 32'd0);
          m_active = 1'b1;
          m_start = cyc;
          m_end = cyc + ((op == 4'd3 || op == 4'd4) ? DC : MC);
        end else if (op == 4'd7) m_hi = A;
        else if (op == 4'd8) m_lo = A;
      end
    end
    cyc++;
  endtask

  task automatic tick(input logic s, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b);
    start = s; op = o; A = a; B = b;
    #1;
    if (m_known) check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, $urandom, $urandom);
  endtask

  initial begin
    cyc = 0; m_start = 0; m_end = 0; m_active = 0; m_known = 0; m_pok = 0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
    @(posedge clk); #1;
    tick(1'b0, 4'd0, 32'd0, 32'd0);
    model_edge_sync: begin end
    reset = 1'b0;
    op = 4'd5; #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_C", C, 32'd0);

    // mult -2 * 3
    tick(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    idle(MC);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);

    // multu max * max
    tick(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(MC);
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);

    // div -7 / 2
    tick(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(DC - 1);
    chk("div_last_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    // div overflow case
    tick(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC);
    chk("divovf_LO", LO, 32'h8000_0000);
    chk("divovf_HI", HI, 32'd0);

    // divide by zero leaves HI/LO alone
    tick(1'b1, 4'd7, 32'hAAAA_5555, 32'd0);
    tick(1'b1, 4'd4, 32'd77, 32'd0);
    idle(DC);
    chk("div0_HI", HI, 32'hAAAA_5555);
    chk("div0_LO", LO, 32'h8000_0000);

    // mtlo while busy is dropped; start in last busy cycle is dropped
    tick(1'b1, 4'd1, 32'd2, 32'd3);
    tick(1'b0, 4'd8, 32'h1234, 32'd0);
    idle(MC - 2);
    tick(1'b1, 4'd3, 32'd100, 32'd7);
    chk("lastbusy_ignored", {31'd0, busy}, 32'd0);
    chk("mtlo_busy_LO", LO, 32'd6);

    // mtlo while idle, read back through mflo
    tick(1'b0, 4'd8, 32'h1234, 32'd0);
    op = 4'd6; #1;
    chk("mflo_C", C, 32'h1234);

    // reset in busy cycle 3 of a div
    tick(1'b1, 4'd4, 32'd1000, 32'd3);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_HI", HI, 32'd0);
    chk("rstmid_LO", LO, 32'd0);
    idle(DC + 2);
    chk("rstmid_nocommit", LO, 32'd0);

    // madd HI=0, LO=all ones, + 1*1
    tick(1'b0, 4'd7, 32'd0, 32'd0);
    tick(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd0);
    tick(1'b1, 4'd9, 32'd1, 32'd1);
    chk("madd_busy", {31'd0, busy}, MADD ? 32'd1 : 32'd0);
    idle(MC);
    chk("madd_HI", HI, MADD ? 32'd1 : 32'd0);
    chk("madd_LO", LO, MADD ? 32'd0 : 32'hFFFF_FFFF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rb;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 16);
        default: rb = $urandom;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom, rb);
    end
    reset = 1'b0;
    idle(DC + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
